// File: rtl/imdct_pkg.sv
// Shared widths and saturation limits for the IMDCT output datapath.
package imdct_pkg;

    localparam int IMDCT_DW = 32;
    localparam int SHAMT_W  = 5;
    localparam int PCM_W    = 16;
    // One guard bit above the IMDCT word so din plus the rounding bias never overflows.
    localparam int ACC_W    = IMDCT_DW + 1;

    // Largest value representable in a signed w-bit word, sign-extended to ACC_W.
    function automatic logic signed [ACC_W-1:0] sat_max(input int w);
        return ACC_W'((64'sd1 <<< (w - 1)) - 64'sd1);
    endfunction

    // Most negative value representable in a signed w-bit word, sign-extended to ACC_W.
    function automatic logic signed [ACC_W-1:0] sat_min(input int w);
        return ACC_W'(-(64'sd1 <<< (w - 1)));
    endfunction

endpackage

// File: rtl/barrel_shifter32_right.sv
// Combinational arithmetic right shifter for the 33-bit rounding sum.
module barrel_shifter32_right
    import imdct_pkg::*;
(
    input  logic signed [ACC_W-1:0]   a,
    input  logic        [SHAMT_W-1:0] sh,
    output logic signed [ACC_W-1:0]   y
);

    // Log-depth shifter: each control bit applies a sign-filling shift of 2^k.
    always_comb begin
        y = a;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (sh[k]) y = y >>> (1 << k);
        end
    end

endmodule

// File: rtl/imdct_rshift_round.sv
// IMDCT output stage: right-shift with optional round-half-up, saturate to PCM,
// mark block boundaries and count saturated samples. Two-stage valid/ready pipeline.
module imdct_rshift_round
    import imdct_pkg::*;
#(
    parameter int OUT_W     = PCM_W,
    parameter int BLOCK_LEN = 36,
    parameter int SATCNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IMDCT_DW-1:0] din,
    input  logic        [SHAMT_W-1:0]  shamt,
    input  logic                       round_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    dout,
    output logic                       out_last,
    output logic        [SATCNT_W-1:0] sat_cnt,
    input  logic                       clear
);

    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = sat_max(OUT_W);
    localparam logic signed [ACC_W-1:0] SAT_LO = sat_min(OUT_W);

    // Half an output LSB at the shifted position; zero for truncation or no shift.
    function automatic logic signed [ACC_W-1:0] round_bias(input logic en,
                                                           input logic [SHAMT_W-1:0] sh);
        if (en && sh != '0) return ACC_W'(1) << (sh - SHAMT_W'(1));
        return '0;
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) return SAT_HI[OUT_W-1:0];
        if (v < SAT_LO) return SAT_LO[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] sum_p0;
    logic signed [ACC_W-1:0] shr_p0;
    logic signed [ACC_W-1:0] shr_p1;
    logic                    vld_p1;
    logic signed [OUT_W-1:0] dout_p2;
    logic                    last_p2;
    logic                    sat_p2;
    logic                    vld_p2;
    logic [CNT_W-1:0]        blk_cnt;
    logic [CNT_W-1:0]        cnt_eff;
    logic                    in_fire;
    logic                    out_fire;
    logic                    ld_p2;
    logic                    s1_adv;

    // ---- p0: sign-extend, add rounding bias, shift (combinational) ----
    assign sum_p0 = {din[IMDCT_DW-1], din} + round_bias(round_en, shamt);

    barrel_shifter32_right u_shift (
        .a  (sum_p0),
        .sh (shamt),
        .y  (shr_p0)
    );

    // Handshake: S2 refills when empty or draining; S1 moves up under the same condition.
    assign out_fire = vld_p2 & out_ready;
    assign ld_p2    = ~vld_p2 | out_ready;
    assign s1_adv   = vld_p1 & ld_p2;
    assign in_ready = ~vld_p1 | ld_p2;
    assign in_fire  = in_valid & in_ready;

    // ---- p1: capture shifted 33-bit value on input transfer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            shr_p1 <= '0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
            shr_p1 <= shr_p0;
        end else if (s1_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    // Block position after this cycle's clear/transfer; also the slot of a sample loading into S2.
    always_comb begin
        cnt_eff = blk_cnt;
        if (clear)         cnt_eff = '0;
        else if (out_fire) cnt_eff = (blk_cnt == CNT_LAST) ? '0 : CNT_W'(blk_cnt + 1'b1);
    end

    // ---- p2: saturate into the output register, tag block end and saturation ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            dout_p2 <= '0;
            last_p2 <= 1'b0;
            sat_p2  <= 1'b0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                dout_p2 <= saturate(shr_p1);
                sat_p2  <= sat_hit(shr_p1);
                last_p2 <= (cnt_eff == CNT_LAST);
            end
        end
    end

    // Output transfers within the current block; clear takes priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blk_cnt <= '0;
        else        blk_cnt <= cnt_eff;
    end

    // Saturated samples counted on their output transfer, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (clear) begin
            sat_cnt <= '0;
        end else if (out_fire && sat_p2 && sat_cnt != '1) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign out_valid = vld_p2;
    assign dout      = dout_p2;
    assign out_last  = last_p2;

endmodule

// File: tb/tb_imdct_rshift_round.sv
// Testbench for imdct_rshift_round: directed vector table, random backpressure
// stream against an arithmetic reference model, block-boundary and reset sequences.
module tb_imdct_rshift_round;

    localparam int OUT_W     = 16;
    localparam int BLOCK_LEN = 36;
    localparam int SATCNT_W  = 16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic        [31:0]         din = '0;
    logic        [4:0]          shamt = '0;
    logic                       round_en = 1'b0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic signed [OUT_W-1:0]    dout;
    logic                       out_last;
    logic        [SATCNT_W-1:0] sat_cnt;
    logic                       clear = 1'b0;

    always #5 clk = ~clk;

    imdct_rshift_round #(
        .OUT_W     (OUT_W),
        .BLOCK_LEN (BLOCK_LEN),
        .SATCNT_W  (SATCNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .round_en  (round_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_last  (out_last),
        .sat_cnt   (sat_cnt),
        .clear     (clear)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        longint val;
        bit     sat;
    } exp_t;

    // Reference: floor((din + bias) / 2^shamt), then clamp to the signed OUT_W range.
    function automatic exp_t ref_model(input logic [31:0] d, input int sh, input bit re);
        longint v, dv, q, lim;
        exp_t   e;
        v  = longint'($signed(d));
        dv = longint'(1) << sh;
        if (re && sh != 0) v = v + dv / 2;
        q = v / dv;
        if ((v % dv) != 0 && v < 0) q = q - 1;
        lim   = longint'(1) << (OUT_W - 1);
        e.sat = 1'b0;
        if (q > lim - 1) begin
            q = lim - 1;
            e.sat = 1'b1;
        end else if (q < -lim) begin
            q = -lim;
            e.sat = 1'b1;
        end
        e.val = q;
        return e;
    endfunction

    exp_t   sb[$];
    int     tr_cnt = 0;
    int     sat_model = 0;
    int     out_idx = 0;
    int     last_idx[$];
    bit     stalled = 1'b0;
    longint stall_d = 0;
    longint stall_l = 0;

    // One clock of the handshake, checked against the scoreboard. Called at posedge+1.
    task automatic cycle(input bit iv, input logic [31:0] d, input logic [4:0] sh,
                         input bit re, input bit ordy, input bit clr, output bit acc);
        bit   ofire;
        exp_t e;
        in_valid = iv; din = d; shamt = sh; round_en = re; out_ready = ordy; clear = clr;
        #1;
        chk("in_ready", in_ready, (sb.size() < 2 || ordy) ? 1 : 0);
        if (sb.size() == 0) chk("idle_valid", out_valid, 0);
        if (stalled) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_dout", dout, stall_d);
            chk("stall_last", out_last, stall_l);
        end
        acc   = iv && in_ready;
        ofire = out_valid && ordy;
        if (ofire) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dout", dout, e.val);
                chk("last", out_last, (tr_cnt == BLOCK_LEN - 1) ? 1 : 0);
                out_idx++;
                if (out_last) last_idx.push_back(out_idx);
                if (!clr && e.sat && sat_model < (1 << SATCNT_W) - 1) sat_model++;
            end
        end
        stalled = out_valid && !ordy;
        stall_d = dout;
        stall_l = out_last;
        if (clr) begin
            tr_cnt = 0;
            sat_model = 0;
        end else if (ofire) begin
            tr_cnt = (tr_cnt + 1) % BLOCK_LEN;
        end
        if (acc) sb.push_back(ref_model(d, int'(sh), re));
        @(posedge clk); #1;
        chk("sat_cnt", sat_cnt, sat_model);
    endtask

    task automatic drain(input string name);
        int n;
        bit a;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, a);
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Single sample with out_ready high: latency, value, then sat_cnt after its transfer.
    task automatic apply_one(input string name, input logic [31:0] d, input logic [4:0] sh,
                             input bit re, input bit clr, input longint exp_d,
                             input longint exp_sat);
        int lat;
        in_valid = 1'b1; din = d; shamt = sh; round_en = re; out_ready = 1'b1; clear = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, lat, 2);
        chk({name, "_dout"}, dout, exp_d);
        clear = clr;
        @(posedge clk); #1;
        clear = 1'b0;
        chk({name, "_satcnt"}, sat_cnt, exp_sat);
        chk({name, "_drop"}, out_valid, 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [4:0]  sh;
        bit          re;
        bit          clr;
        longint      ed;
        longint      es;
    } vec_t;

    vec_t        tbl[13];
    bit          acc;
    bit          iv, re, ordy;
    logic [31:0] d;
    logic [4:0]  sh;
    int          sent, cyc;
    exp_t        e;

    initial begin
        tbl[0]  = '{"rnd_pos",   32'h0001_8000, 5'd16, 1'b1, 1'b0,      2, 0};
        tbl[1]  = '{"trc_pos",   32'h0001_8000, 5'd16, 1'b0, 1'b0,      1, 0};
        tbl[2]  = '{"rnd_neg",   32'hFFFF_8000, 5'd16, 1'b1, 1'b0,      0, 0};
        tbl[3]  = '{"trc_neg",   32'hFFFF_8000, 5'd16, 1'b0, 1'b0,     -1, 0};
        tbl[4]  = '{"sat_hi",    32'h7FFF_FFFF, 5'd8,  1'b1, 1'b0,  32767, 1};
        tbl[5]  = '{"sat_lo",    32'h8000_0000, 5'd0,  1'b1, 1'b0, -32768, 2};
        tbl[6]  = '{"pass",      32'h0000_1234, 5'd0,  1'b1, 1'b0,   4660, 2};
        tbl[7]  = '{"max_sh31",  32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0,      1, 2};
        tbl[8]  = '{"min_sh31",  32'h8000_0000, 5'd31, 1'b1, 1'b0,     -1, 2};
        tbl[9]  = '{"edge_hi",   32'h0000_7FFF, 5'd0,  1'b0, 1'b0,  32767, 2};
        tbl[10] = '{"edge_lo",   32'hFFFF_7FFF, 5'd0,  1'b0, 1'b0, -32768, 3};
        tbl[11] = '{"clr_sat",   32'h7FFF_FFFF, 5'd0,  1'b0, 1'b1,  32767, 0};
        tbl[12] = '{"after_clr", 32'h8000_0000, 5'd4,  1'b0, 1'b0, -32768, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", out_last, 0);
        chk("rst_satcnt", sat_cnt, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 13; i++)
            apply_one(tbl[i].name, tbl[i].d, tbl[i].sh, tbl[i].re, tbl[i].clr,
                      tbl[i].ed, tbl[i].es);

        // Random stream with random backpressure
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, acc);
        out_idx = 0;
        last_idx.delete();
        sent = 0;
        cyc = 0;
        while (sent < 100 && cyc < 2000) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = $urandom_range(0, 1);
            re   = $urandom_range(0, 1);
            sh   = 5'($urandom_range(0, 31));
            d    = $urandom;
            if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            cycle(iv, d, sh, re, ordy, 1'b0, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("rand_sent", sent, 100);
        drain("rand_drain");

        // Block boundaries over 80 back-to-back samples
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, acc);
        out_idx = 0;
        last_idx.delete();
        for (int i = 0; i < 80; i++)
            cycle(1'b1, $urandom, 5'($urandom_range(8, 20)), 1'b1, 1'b1, 1'b0, acc);
        drain("blk_drain");
        chk("blk_nlast", last_idx.size(), 2);
        chk("blk_last0", (last_idx.size() > 0) ? last_idx[0] : -1, 36);
        chk("blk_last1", (last_idx.size() > 1) ? last_idx[1] : -1, 72);

        // Clear after output 40 shifts the next boundary to output 76
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, acc);
        out_idx = 0;
        last_idx.delete();
        for (int i = 0; i < 40; i++)
            cycle(1'b1, $urandom, 5'($urandom_range(8, 20)), 1'b0, 1'b1, 1'b0, acc);
        drain("clr_drain_a");
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 40; i++)
            cycle(1'b1, $urandom, 5'($urandom_range(8, 20)), 1'b0, 1'b1, 1'b0, acc);
        drain("clr_drain_b");
        chk("clr_nlast", last_idx.size(), 2);
        chk("clr_last0", (last_idx.size() > 0) ? last_idx[0] : -1, 36);
        chk("clr_last1", (last_idx.size() > 1) ? last_idx[1] : -1, 76);

        // Reset with both stages occupied
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, acc);
        cycle(1'b1, 32'h7FFF_FFFF, 5'd0, 1'b0, 1'b1, 1'b0, acc);
        drain("mid_pre_drain");
        cycle(1'b1, 32'h0001_2345, 5'd4, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0005_4321, 5'd4, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, acc);
        chk("mid_full_valid", out_valid, 1);
        chk("mid_full_satcnt", sat_cnt, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_satcnt", sat_cnt, 0);
        chk("mid_rst_dout", dout, 0);
        sb.delete();
        tr_cnt = 0;
        sat_model = 0;
        stalled = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        e = ref_model(32'hFFF0_1234, 8, 1'b1);
        apply_one("mid_post", 32'hFFF0_1234, 5'd8, 1'b1, 1'b0, e.val, e.sat ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
